// File: rtl/gate_mac_requant_if.sv
// Handshake bundle between the operand feeder, the gate MAC and the tanh PLA.
// The operand stream carries (x, w, bias). The result side carries the
// requantised pre-activation together with its saturation flag.
interface gate_mac_requant_if #(
  parameter int W_DATA = 8,
  parameter int W_OUT  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [W_DATA-1:0] in_x;
  logic signed [W_DATA-1:0] in_w;
  logic signed [W_DATA-1:0] in_bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [W_OUT-1:0]  out_data;
  logic                     out_sat;

  // Feeder / PLA side.
  modport master (
    output in_valid, in_x, in_w, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // MAC side.
  modport slave (
    input  in_valid, in_x, in_w, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/gate_mac_requant.sv
// Sequential MAC for one LSTM gate pre-activation: bias + sum(x[k]*w[k]).
// The result is rounded (half toward +inf) and saturated into the PLA input
// format Q(OUT_I).(W_OUT-OUT_I). It is held until the PLA accepts it.
// The product of the element just accepted is registered. It is folded into
// the accumulator on the next acceptance, or in DRAIN for the last element.
module gate_mac_requant #(
  parameter int W_DATA = 8,
  parameter int DATA_F = 6,
  parameter int N      = 4,
  parameter int W_ACC  = 20,
  parameter int W_OUT  = 8,
  parameter int OUT_I  = 4
) (
  input logic              clock,
  input logic              resetn,
  gate_mac_requant_if.slave bus
);

  localparam int W_PROD = 2 * W_DATA;
  localparam int IDX_W  = $clog2(N);
  localparam int OUT_F  = W_OUT - OUT_I;
  localparam int SH     = 2 * DATA_F - OUT_F;

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N - 1);
  localparam logic signed [W_ACC:0] RND      = (W_ACC + 1)'(64'sd1 <<< (SH - 1));
  localparam logic signed [W_ACC:0] SAT_MAX  = (W_ACC + 1)'((64'sd1 <<< (W_OUT - 1)) - 64'sd1);
  localparam logic signed [W_ACC:0] SAT_MIN  = -SAT_MAX - (W_ACC + 1)'(1);

  typedef enum logic [1:0] {ACC, DRAIN, RQ, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [W_ACC-1:0]   acc_q, acc_d;
  logic signed [W_PROD-1:0]  prod_q, prod_d;
  logic                      in_ready_q;
  logic                      out_valid_q, out_valid_d;
  logic signed [W_OUT-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [W_PROD-1:0]  x_ext, w_ext;
  logic [W_OUT:0]            rq;

  // Round half toward +inf and clip. The sum is formed one bit wider than
  // the accumulator so the rounding addend cannot wrap.
  // Returns {sat, data}.
  function automatic logic [W_OUT:0] requant(input logic signed [W_ACC-1:0] a);
    logic signed [W_ACC:0] s;
    logic signed [W_ACC:0] r;
    s = {a[W_ACC-1], a} + RND;
    r = s >>> SH;
    if (r > SAT_MAX)      requant = {1'b1, SAT_MAX[W_OUT-1:0]};
    else if (r < SAT_MIN) requant = {1'b1, SAT_MIN[W_OUT-1:0]};
    else                  requant = {1'b0, r[W_OUT-1:0]};
  endfunction

  assign x_ext = W_PROD'(bus.in_x);
  assign w_ext = W_PROD'(bus.in_w);
  assign rq    = requant(acc_q);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  // State, datapath and output registers. Reset clears all partial work.
  // in_ready is a registered decode of the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ACC;
      idx_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      in_ready_q  <= (state_d == ACC);
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Next-state and datapath update for ACC -> DRAIN -> RQ -> HOLD.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      ACC: begin
        if (bus.in_valid && in_ready_q) begin
          prod_d = x_ext * w_ext;
          // Element 0 restarts from the bias. Any stale product is dropped.
          if (idx_q == '0) acc_d = W_ACC'(bus.in_bias) <<< DATA_F;
          else             acc_d = acc_q + W_ACC'(prod_q);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        acc_d   = acc_q + W_ACC'(prod_q);
        state_d = RQ;
      end
      RQ: begin
        {out_sat_d, out_data_d} = rq;
        out_valid_d             = 1'b1;
        state_d                 = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

endmodule

// File: tb/tb_gate_mac_requant.sv
// Bench for gate_mac_requant: directed corner vectors plus random vectors with
// input bubbles and output backpressure, against a plain-arithmetic model.
module tb_gate_mac_requant;

  localparam int W_DATA = 8;
  localparam int DATA_F = 6;
  localparam int N      = 4;
  localparam int W_ACC  = 20;
  localparam int W_OUT  = 8;
  localparam int OUT_I  = 4;

  logic clock;
  logic resetn;
  int   n_chk;
  int   n_pass;

  gate_mac_requant_if #(.W_DATA(W_DATA), .W_OUT(W_OUT)) bus ();

  gate_mac_requant #(
    .W_DATA(W_DATA), .DATA_F(DATA_F), .N(N),
    .W_ACC(W_ACC), .W_OUT(W_OUT), .OUT_I(OUT_I)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Floor division by 2^k for any sign, written without shifts.
  function automatic int floor_div(input int a, input int d);
    if (a >= 0) floor_div = a / d;
    else        floor_div = -((-a + d - 1) / d);
  endfunction

  // Real-valued view: value = bias/64 + sum(x*w)/4096. The output LSB is 1/16.
  // The model rounds half up to that LSB and clips to the signed 8-bit range.
  function automatic void ref_model(input int bias, input int xs[N], input int ws[N],
                                    output int data, output int sat);
    int acc;
    int r;
    acc = bias * 64;
    for (int k = 0; k < N; k++) acc += xs[k] * ws[k];
    r = floor_div(acc + 128, 256);
    sat = 0;
    if (r > 127)       begin r = 127;  sat = 1; end
    else if (r < -128) begin r = -128; sat = 1; end
    data = r;
  endfunction

  // Stream one vector, wait for the result, optionally stall the output,
  // then complete the output handshake.
  task automatic run_vector(input string tag, input int bias, input int xs[N],
                            input int ws[N], input bit bubbles, input int hold);
    int exp_d, exp_s, n, lat;
    ref_model(bias, xs, ws, exp_d, exp_s);
    bus.out_ready = (hold == 0);
    for (int k = 0; k < N; k++) begin
      if (bubbles) begin
        n = $urandom_range(0, 2);
        for (int b = 0; b < n; b++) begin
          bus.in_valid = 1'b0;
          bus.in_x     = W_DATA'($urandom);
          @(negedge clock);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_x     = W_DATA'(xs[k]);
      bus.in_w     = W_DATA'(ws[k]);
      bus.in_bias  = (k == 0) ? W_DATA'(bias) : W_DATA'($urandom);
      n = 0;
      while (!bus.in_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) chk({tag, "_in_ready_timeout"}, 0, 1);
      @(posedge clock);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      chk({tag, "_in_ready_busy"}, int'(bus.in_ready), 0);
      lat++;
      @(negedge clock);
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_data"}, int'(bus.out_data), exp_d);
    chk({tag, "_sat"}, int'(bus.out_sat), exp_s);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({tag, "_hold_ready"}, int'(bus.in_ready), 0);
      chk({tag, "_hold_data"}, int'(bus.out_data), exp_d);
      chk({tag, "_hold_sat"}, int'(bus.out_sat), exp_s);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk({tag, "_after_xfer_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_after_xfer_ready"}, int'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
  endtask

  // Accept a few pairs, leaving the vector unfinished.
  task automatic feed_pairs(input int count);
    int n;
    for (int k = 0; k < count; k++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = W_DATA'(64);
      bus.in_w     = W_DATA'(64);
      bus.in_bias  = W_DATA'(100);
      n = 0;
      while (!bus.in_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) chk("feed_in_ready_timeout", 0, 1);
      @(posedge clock);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"}, int'(bus.out_data), 0);
    chk({tag, "_out_sat"}, int'(bus.out_sat), 0);
  endtask

  initial begin
    int xs[N];
    int ws[N];
    int bias;
    n_chk  = 0;
    n_pass = 0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_w      = '0;
    bus.in_bias   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);
    chk("ready_after_release", int'(bus.in_ready), 1);

    // Nominal: 1.0 * 1.0 four times -> 4.0.
    xs = '{64, 64, 64, 64}; ws = '{64, 64, 64, 64};
    run_vector("nominal", 0, xs, ws, 1'b0, 0);

    // Positive and negative saturation.
    xs = '{127, 127, 127, 127}; ws = '{127, 127, 127, 127};
    run_vector("pos_sat", 127, xs, ws, 1'b0, 0);
    xs = '{-128, -128, -128, -128}; ws = '{127, 127, 127, 127};
    run_vector("neg_sat", -128, xs, ws, 1'b0, 0);

    // Rounding at the half-LSB boundaries.
    xs = '{64, 0, 0, 0}; ws = '{2, 0, 0, 0};
    run_vector("round_up", 0, xs, ws, 1'b0, 0);
    xs = '{127, 0, 0, 0}; ws = '{1, 0, 0, 0};
    run_vector("round_below", 0, xs, ws, 1'b0, 0);
    xs = '{-64, 0, 0, 0}; ws = '{2, 0, 0, 0};
    run_vector("round_neg_half", 0, xs, ws, 1'b0, 0);

    // Handshake stress: bubbles and a 5-cycle stall, then a random follow-up.
    xs = '{33, -71, 12, 90}; ws = '{-5, 40, 127, -66};
    run_vector("stall", 17, xs, ws, 1'b1, 5);
    for (int v = 0; v < 10; v++) begin
      bias = int'($signed(8'($urandom)));
      for (int k = 0; k < N; k++) begin
        xs[k] = int'($signed(8'($urandom)));
        ws[k] = int'($signed(8'($urandom)));
      end
      run_vector("random", bias, xs, ws, 1'b1, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a vector.
    feed_pairs(2);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset_mid_vector");
    @(negedge clock);
    resetn = 1'b1;
    xs = '{64, 64, 64, 64}; ws = '{64, 64, 64, 64};
    run_vector("after_reset_vec", 0, xs, ws, 1'b0, 0);

    // Asynchronous reset while a result is being held.
    xs = '{127, 127, 127, 127}; ws = '{127, 127, 127, 127};
    bus.out_ready = 1'b0;
    feed_pairs(N);
    repeat (4) @(negedge clock);
    chk("hold_before_reset_valid", int'(bus.out_valid), 1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset_mid_hold");
    @(negedge clock);
    resetn = 1'b1;
    xs = '{64, 64, 64, 64}; ws = '{64, 64, 64, 64};
    run_vector("after_reset_hold", 0, xs, ws, 1'b1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_mac_requant.md
# gate_mac_requant

Upstream feeder for the shift-based tanh PLA: a sequential multiply-accumulate that computes one LSTM gate pre-activation, bias + Σ x[k]·w[k] over an N-element vector. The result is rounded and saturated into the PLA's signed fixed-point input format (W_OUT bits, OUT_I integer bits including sign). Operands stream in through a valid/ready handshake. The single requantised result is held in an output register until the PLA stage accepts it.

## Interface
- W_DATA, 8: operand width (x, w, bias); signed two's complement.
- DATA_F, 6: fractional bits of x, w and bias.
- N, 4: vector length (elements per result); N ≥ 2.
- W_ACC, 20: accumulator width; must be ≥ 2·W_DATA + clog2(N) so the accumulator never overflows.
- W_OUT, 8: output width; equals the PLA's W_IN.
- OUT_I, 4: output integer bits including sign; equals the PLA's IN_I. Constraint: 2·DATA_F > W_OUT − OUT_I.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operand pair is present.
- in_ready  out  1  block accepts a pair this cycle.
- in_x  in  W_DATA  activation element.
- in_w  in  W_DATA  weight element.
- in_bias  in  W_DATA  gate bias; sampled only with element 0.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W_OUT  requantised pre-activation, format Q(OUT_I).(W_OUT−OUT_I).
- out_sat  out  1  result was clipped; qualified by out_valid.

## Operation
- **Derived values:** OUT_F = W_OUT − OUT_I; SH = 2·DATA_F − OUT_F.
- **FSM states:** ACC, DRAIN, RQ, HOLD. Reset state is ACC.
- **ACC state:**
  - in_ready = 1. A pair is accepted when in_valid & in_ready.
  - On acceptance, prod_reg <= in_x·in_w (signed, 2·W_DATA bits).
  - Element index idx counts 0..N−1.
  - On acceptance of idx 0: acc <= sign-extended in_bias << DATA_F, and any pending prod_reg is discarded.
  - On acceptance of idx > 0: acc <= acc + prod_reg, which adds the previous element's product.
  - On acceptance of idx N−1: idx <= 0 and the state goes to DRAIN.
  - While in_valid = 0, nothing changes; bubbles are allowed.
- **DRAIN state:** acc <= acc + prod_reg, then go to RQ. in_ready = 0.
- **RQ state:**
  - r = (acc + 2^(SH−1)) >>> SH. This is round-half-toward-+∞ with an arithmetic shift.
  - If r > 2^(W_OUT−1)−1: out_data <= 2^(W_OUT−1)−1, out_sat <= 1.
  - If r < −2^(W_OUT−1): out_data <= −2^(W_OUT−1), out_sat <= 1.
  - Otherwise out_data <= r[W_OUT−1:0], out_sat <= 0.
  - out_valid <= 1, then go to HOLD.
- **HOLD state:**
  - in_ready = 0; out_data and out_sat are stable.
  - On out_valid & out_ready: out_valid <= 0, then go to ACC.
- **Reset:** in_ready, out_valid, out_data, out_sat, acc, prod_reg and idx are all 0, and the state is ACC. Reset asserted mid-vector or mid-HOLD discards all partial state. The next accepted pair is treated as idx 0.
- **Width of the rounding sum:** the rounding addition and comparison are evaluated at W_ACC+1 bits, so the rounding addend itself cannot wrap.

## Timing
- in_ready is a registered state decode: 1 only in ACC, including the cycle immediately after reset release.
- **Latency:** last element accepted at edge E → out_valid high after edge E+2 (E+1 DRAIN, E+2 RQ).
- **Throughput:** with out_ready held at 1, the transfer occurs at edge E+3. First element of the next vector can be accepted at edge E+4. That gives N+3 cycles per result, plus input bubbles.
- **Backpressure:** out_valid stays high and out_data/out_sat stay unchanged until the handshake. in_ready stays 0 for that whole interval.
- **Simultaneous events:** out_ready high during RQ has no effect, because out_valid is not yet 1.

## Test plan
Parameters for all scenarios: W_DATA=8, DATA_F=6, N=4, W_OUT=8, OUT_I=4, SH=8.

1. **Nominal:** 4 pairs x=64, w=64 (1.0·1.0), bias=0 → out_data=0x40 (4.0), out_sat=0. out_valid rises 2 edges after the 4th acceptance.
2. **Positive saturation:** 4 pairs x=127, w=127, bias=127 → acc=72644 → out_data=0x7F, out_sat=1.
3. **Negative saturation:** 4 pairs x=−128, w=127, bias=−128 → acc=−73216 → out_data=0x80, out_sat=1.
4. **Rounding:** element 0 x=64, w=2 (product 128), others 0, bias 0 → 0x01. Product 127 (x=127, w=1) → 0x00. Product −128 (x=−64, w=2) → 0x00.
5. **Handshake stress:** random in_valid bubbles; out_ready held low 5 cycles in HOLD → out_data stable, in_ready=0 throughout. The next vector is unaffected and matches a scoreboard.
6. **Reset mid-vector:** resetn pulsed low after 2 accepted pairs → all outputs 0 immediately (asynchronous). A fresh 4-pair vector after release produces the scenario-1 result.
